// File: rtl/special_alu_pkg.sv
// Shared opcodes and helpers for the parametrised special ALU.
package special_alu_pkg;

  localparam logic [3:0] OP_ADD2 = 4'd0;
  localparam logic [3:0] OP_SUB2 = 4'd1;
  localparam logic [3:0] OP_OR2  = 4'd2;
  localparam logic [3:0] OP_AND2 = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_SUM  = 4'd6;
  localparam logic [3:0] OP_AVG  = 4'd7;
  localparam logic [3:0] OP_MIN  = 4'd8;
  localparam logic [3:0] OP_MAX  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic is_pairwise(input logic [3:0] op);
    return op <= OP_AND2;
  endfunction

  function automatic logic is_reduction(input logic [3:0] op);
    return (op >= OP_OR) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/special_alu_ring.sv
// Operand ring buffer: push one, pop n per cycle, synchronous flush.
module special_alu_ring #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CW    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DW-1:0]               din,
  input  logic                        pop,
  input  logic [CW-1:0]               pop_n,
  output logic [DEPTH-1:0][DW-1:0]    win,
  output logic [CW-1:0]               cnt
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Storage is intentionally left unreset; only the bookkeeping defines validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + pop_n[AW-1:0];
      cnt <= cnt + CW'(push) - (pop ? pop_n : '0);
    end
  end

  // Window presented oldest-first so consumers never deal with pointer math.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      win[i] = mem[rd_ptr + AW'(i)];
    end
  end

endmodule

// File: rtl/special_alu_param.sv
// Buffered special ALU: pairwise ops on the two oldest operands or reductions over all.
module special_alu_param
  import special_alu_pkg::*;
#(
  parameter  int DW       = 8,
  parameter  int DEPTH    = 8,
  parameter  int POP_MODE = 0,
  localparam int AW       = clog2(DEPTH),
  localparam int CW       = AW + 1,
  localparam int RW       = DW + AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          a_valid,
  input  logic [DW-1:0] a_operand,
  output logic          a_ready,
  input  logic [3:0]    b_operation,
  output logic          b_valid,
  output logic [RW-1:0] b_result,
  input  logic          b_ready,
  output logic [CW-1:0] level
);

  logic [DEPTH-1:0][DW-1:0] win;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            pop_n;
  logic                     pairwise;
  logic                     reduction;
  logic                     a_hs;
  logic                     b_hs;
  logic [RW-1:0]            e0, e1;
  logic [RW-1:0]            sum, or_r, and_r, min_r, max_r, xor_r, avg;
  logic [RW-1:0]            res;

  special_alu_ring #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (a_hs),
    .din   (a_operand),
    .pop   (b_hs),
    .pop_n (pop_n),
    .win   (win),
    .cnt   (cnt)
  );

  // Reductions seed from the oldest entry so AND/MIN never see an identity value.
  always_comb begin
    e0    = RW'(win[0]);
    e1    = RW'(win[1]);
    sum   = e0;
    or_r  = e0;
    and_r = e0;
    min_r = e0;
    max_r = e0;
    xor_r = e0;
    for (int i = 1; i < DEPTH; i++) begin
      if (CW'(i) < cnt) begin
        sum   = sum + RW'(win[i]);
        or_r  = or_r | RW'(win[i]);
        and_r = and_r & RW'(win[i]);
        xor_r = xor_r ^ RW'(win[i]);
        if (RW'(win[i]) < min_r) min_r = RW'(win[i]);
        if (RW'(win[i]) > max_r) max_r = RW'(win[i]);
      end
    end
    avg = sum / ((cnt == '0) ? RW'(1) : RW'(cnt));
  end

  always_comb begin
    pairwise  = is_pairwise(b_operation);
    reduction = is_reduction(b_operation);
    res       = '0;
    unique case (b_operation)
      OP_ADD2: res = e0 + e1;
      OP_SUB2: res = e0 - e1;
      OP_OR2:  res = e0 | e1;
      OP_AND2: res = e0 & e1;
      OP_OR:   res = or_r;
      OP_AND:  res = and_r;
      OP_SUM:  res = sum;
      OP_AVG:  res = avg;
      OP_MIN:  res = min_r;
      OP_MAX:  res = max_r;
      OP_XOR:  res = xor_r;
      default: res = '0;
    endcase
  end

  always_comb begin
    b_valid  = pairwise ? (cnt >= CW'(2)) : (reduction ? (cnt >= CW'(1)) : 1'b0);
    b_result = b_valid ? res : '0;
    b_hs     = b_valid & b_ready & ~flush;
    a_ready  = ~flush & ((cnt < CW'(DEPTH)) | b_hs);
    a_hs     = a_valid & a_ready;
    if (POP_MODE == 0) pop_n = CW'(1);
    else               pop_n = pairwise ? CW'(2) : cnt;
    level    = cnt;
  end

endmodule

// File: tb/tb_special_alu_param.sv
// Directed bench for special_alu_param in both pop modes.
module tb_special_alu_param;
  import special_alu_pkg::*;

  logic        clk;
  logic        rst;
  int          n_checks;
  int          n_errors;

  logic        flush0, a_valid0, a_ready0, b_valid0, b_ready0;
  logic [7:0]  a_operand0;
  logic [3:0]  op0;
  logic [10:0] b_result0;
  logic [3:0]  level0;

  logic        flush1, a_valid1, a_ready1, b_valid1, b_ready1;
  logic [7:0]  a_operand1;
  logic [3:0]  op1;
  logic [10:0] b_result1;
  logic [3:0]  level1;

  special_alu_param #(.DW(8), .DEPTH(8), .POP_MODE(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush0), .a_valid(a_valid0), .a_operand(a_operand0),
    .a_ready(a_ready0), .b_operation(op0), .b_valid(b_valid0), .b_result(b_result0),
    .b_ready(b_ready0), .level(level0)
  );

  special_alu_param #(.DW(8), .DEPTH(8), .POP_MODE(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush1), .a_valid(a_valid1), .a_operand(a_operand1),
    .a_ready(a_ready1), .b_operation(op1), .b_valid(b_valid1), .b_result(b_result1),
    .b_ready(b_ready1), .level(level1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] d);
    a_valid0 = 1'b1;
    a_operand0 = d;
    cyc();
    a_valid0 = 1'b0;
  endtask

  task automatic push1(input logic [7:0] d);
    a_valid1 = 1'b1;
    a_operand1 = d;
    cyc();
    a_valid1 = 1'b0;
  endtask

  task automatic flush_u0();
    flush0 = 1'b1;
    cyc();
    flush0 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    flush0 = 0; a_valid0 = 0; a_operand0 = '0; b_ready0 = 0; op0 = OP_SUM;
    flush1 = 0; a_valid1 = 0; a_operand1 = '0; b_ready1 = 0; op1 = OP_SUM;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // asynchronous reset with data buffered
    push0(8'h11);
    push0(8'h22);
    #1;
    check("pre_rst_level", level0, 4'd2);
    #1;
    rst = 1'b1;
    #1;
    check("rst_a_ready", a_ready0, 1'b1);
    check("rst_b_valid", b_valid0, 1'b0);
    check("rst_level", level0, 4'd0);
    check("rst_b_result", b_result0, 11'h000);
    cyc();
    rst = 1'b0;
    cyc();
    check("rst_rd_ptr", u0.u_ring.rd_ptr, 3'd0);
    check("rst_wr_ptr", u0.u_ring.wr_ptr, 3'd0);
    check("rst_level_after", level0, 4'd0);

    // pairwise add/sub
    push0(8'h10);
    push0(8'h05);
    op0 = OP_ADD2; #1;
    check("add2", b_result0, 11'h015);
    check("add2_valid", b_valid0, 1'b1);
    op0 = OP_SUB2; #1;
    check("sub2", b_result0, 11'h00B);
    flush_u0();
    push0(8'h05);
    push0(8'h10);
    #1;
    check("sub2_wrap", b_result0, 11'h7F5);
    flush_u0();
    push0(8'h05);
    op0 = OP_ADD2; #1;
    check("add2_cnt1_valid", b_valid0, 1'b0);
    check("add2_cnt1_result", b_result0, 11'h000);

    // fill with 0xFF, ninth push held
    flush_u0();
    for (int i = 0; i < 8; i++) push0(8'hFF);
    #1;
    check("full_level", level0, 4'd8);
    check("full_a_ready", a_ready0, 1'b0);
    push0(8'h77);
    #1;
    check("held_level", level0, 4'd8);
    op0 = OP_SUM; #1;
    check("sum_ff", b_result0, 11'h7F8);
    op0 = OP_AVG; #1;
    check("avg_ff", b_result0, 11'h0FF);
    op0 = OP_AND; #1;
    check("and_ff", b_result0, 11'h0FF);
    op0 = OP_XOR; #1;
    check("xor_ff", b_result0, 11'h000);

    // full with simultaneous push and pop, pointer wrap
    flush_u0();
    for (int i = 1; i <= 8; i++) push0(8'(i));
    op0 = OP_SUM; #1;
    check("sum_1_8", b_result0, 11'h024);
    a_valid0 = 1'b1;
    a_operand0 = 8'h09;
    b_ready0 = 1'b1;
    #1;
    check("full_pushpop_a_ready", a_ready0, 1'b1);
    cyc();
    a_valid0 = 1'b0;
    b_ready0 = 1'b0;
    #1;
    check("pushpop_level", level0, 4'd8);
    check("sum_2_9", b_result0, 11'h02C);
    check("wrap_wr_ptr", u0.u_ring.wr_ptr, 3'd1);
    check("wrap_rd_ptr", u0.u_ring.rd_ptr, 3'd1);
    op0 = OP_ADD2; #1;
    check("add2_after_wrap", b_result0, 11'h005);

    // pop mode 1
    push1(8'd3);
    push1(8'd9);
    push1(8'd4);
    op1 = OP_MIN; #1;
    check("pm1_min", b_result1, 11'd3);
    op1 = OP_MAX; #1;
    check("pm1_max", b_result1, 11'd9);
    op1 = OP_AVG; #1;
    check("pm1_avg", b_result1, 11'd5);
    op1 = OP_MIN;
    b_ready1 = 1'b1;
    cyc();
    b_ready1 = 1'b0;
    #1;
    check("pm1_min_pop_level", level1, 4'd0);
    push1(8'd3);
    push1(8'd9);
    push1(8'd4);
    op1 = OP_ADD2; #1;
    check("pm1_add2", b_result1, 11'h00C);
    b_ready1 = 1'b1;
    cyc();
    b_ready1 = 1'b0;
    #1;
    check("pm1_add2_pop_level", level1, 4'd1);
    op1 = OP_SUM; #1;
    check("pm1_e0", b_result1, 11'd4);

    // flush beats both handshakes
    flush_u0();
    push0(8'h21);
    push0(8'h42);
    op0 = OP_SUM;
    flush0 = 1'b1;
    a_valid0 = 1'b1;
    a_operand0 = 8'h33;
    b_ready0 = 1'b1;
    #1;
    check("flush_a_ready", a_ready0, 1'b0);
    cyc();
    flush0 = 1'b0;
    a_valid0 = 1'b0;
    b_ready0 = 1'b0;
    #1;
    check("flush_level", level0, 4'd0);
    push0(8'h07);
    op0 = 4'd12; #1;
    check("reserved_valid", b_valid0, 1'b0);
    check("reserved_result", b_result0, 11'h000);
    op0 = OP_SUM; #1;
    check("post_flush_sum", b_result0, 11'h007);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/special_alu_param.md
# special_alu_param

Parametrised successor of the 8-deep, 8-bit special ALU. It buffers up to DEPTH operands from a valid/ready input stream in a ring buffer and presents one combinational result on a valid/ready output stream. The result is either a pairwise operation on the two oldest entries or a reduction over every buffered entry. Compared with the fixed block it adds configurable width and depth, MIN/MAX/XOR reductions, an operand-consuming pop mode, a synchronous flush, and an occupancy output.

## Interface
- DW, 8: operand width, ≥2.
- DEPTH, 8: buffer entries, power of two, 2..64.
- POP_MODE, 0: 0 = each b handshake pops one entry; 1 = each b handshake pops the operands it consumed.
- Derived: AW = log2(DEPTH), CW = AW+1, RW = DW+AW.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous buffer clear.
- a_valid  in  1  operand valid.
- a_operand  in  DW  operand.
- a_ready  out  1  operand accepted when high together with a_valid.
- b_operation  in  4  opcode; must be held stable while b_valid=1 and b_ready=0.
- b_valid  out  1  result valid.
- b_result  out  RW  result.
- b_ready  in  1  result consumer ready.
- level  out  CW  current entry count (cnt).

## Operation
- State: storage mem[DEPTH], rd_ptr[AW], wr_ptr[AW], cnt[CW]. Pointers wrap modulo DEPTH. e0 = mem[rd_ptr] is the oldest entry; e1 = mem[rd_ptr+1].
- Opcodes: 0 ADD2 (e0+e1), 1 SUB2 (e0−e1), 2 OR2, 3 AND2, 4 OR, 5 AND, 6 SUM, 7 AVG, 8 MIN, 9 MAX, 10 XOR. Codes 11..15 are reserved.
- Pairwise ops (0..3): b_valid = (cnt ≥ 2).
- Reduction ops (4..10): operate over all cnt entries; b_valid = (cnt ≥ 1).
- Reserved ops: b_valid = 0.
- Width rules:
  - Operands are zero-extended to RW.
  - SUB2 wraps as two's complement in RW bits.
  - SUM is exact, since DEPTH·(2^DW−1) fits in RW bits.
  - AVG = floor(SUM/cnt).
  - AND, MIN, MAX and XOR are computed over entries only, with no identity leakage.
- b_result = 0 whenever b_valid = 0.
- Handshakes: a_hs = a_valid & a_ready & !flush; b_hs = b_valid & b_ready & !flush.
- Pop count n on b_hs:
  - POP_MODE=0: n = 1.
  - POP_MODE=1: n = 2 for pairwise ops, n = cnt for reduction ops.
- a_ready = !flush & (cnt < DEPTH | b_hs). The path from b_ready to a_ready is combinational. There is no combinational path from a_valid to b_*.
- On a_hs: mem[wr_ptr] ← a_operand; wr_ptr += 1.
- On b_hs: rd_ptr += n.
- Next cnt = cnt + a_hs − (b_hs ? n : 0).
- flush: rd_ptr, wr_ptr, cnt ← 0. It takes priority over both handshakes, which are suppressed that cycle. mem contents are not cleared.
- Full with simultaneous push and pop: legal. The write lands in a freed slot. cnt becomes DEPTH+1−n.

## Timing
- Reset values: a_ready = 1, b_valid = 0, b_result = 0, level = 0; pointers 0. mem is not reset.
- Asserting rst mid-operation discards all buffered data immediately, without waiting for a clock edge.
- Push-to-visible latency: one cycle. An operand accepted at edge k contributes to b_result from edge k onward, never in the same cycle.
- b_valid and b_result are combinational from registered state and b_operation, with zero latency after an op change.
- One b transaction per cycle. Throughput is one push plus one pop per cycle.

## Structure
- Package special_alu_pkg:
  - 4-bit opcode localparams OP_ADD2..OP_XOR.
  - An is_pairwise() function.
  - A clog2 helper for AW and RW.
- Sub-module special_alu_ring: mem, pointers, cnt, flush, and push/pop by n. It exports the window contents and cnt.
- The reduction and divide datapath stays in the top module.

## Test plan
- Reset with rst=1 held mid-stream, DW=8, DEPTH=8 -> a_ready=1, b_valid=0, level=0, b_result=0 with no clock edge; all pointers 0 after release.
- Push 0x10, 0x05 -> ADD2 gives 0x015, SUB2 gives 0x00B. Then flush and push 0x05, 0x10 -> SUB2 gives 0x7F5. With cnt=1, ADD2 gives b_valid=0.
- Push eight 0xFF with b_ready=0 -> level=8 and a_ready=0. A 9th push is held. SUM=0x7F8, AVG=0x0FF, AND=0x0FF, XOR=0x000.
- POP_MODE=0, full buffer holding 1..8, push 0x09 with op SUM and b_ready=1 in the same cycle -> level stays 8, next SUM=0x02C, and wr_ptr wraps correctly.
- POP_MODE=1, entries 3, 9, 4 -> MIN=3, MAX=9, AVG=5. A b_hs on MIN empties the buffer (level=0). Then entries 3, 9, 4 again, ADD2 b_hs leaves level=1 with e0=4.
- flush=1 with a_valid=1 and b_ready=1 -> a_ready=0, no push and no pop that cycle, level=0 next cycle, reserved op 12 gives b_valid=0.
